pwm_envelope_gen: RTL and testbench

- Multi-channel PWM generator with envelope modulation. Successor to the single-channel gated-square PWM.
- One shared PWM counter, phase counter and amplitude ramp drive N_CH channels.
- Each channel has its own mode, enable and phase offset.
- Duty updates are double-buffered at PWM period boundaries, so output is glitch-free. It feeds the analog drive stage via RC filtering.

---
 rtl/pwm_envelope_gen.sv | 99 +++++++++
 tb/tb_pwm_envelope_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_envelope_gen.sv
// Multi-channel PWM generator: one shared PWM counter, envelope phase and amplitude ramp.
// Per-channel duty values are latched at period boundaries, so each PWM period is glitch-free.
module pwm_envelope_gen #(
  parameter int PWM_W   = 6,
  parameter int PHASE_W = 6,
  parameter int N_CH    = 2
) (
  input  logic                      sysclk,
  input  logic                      rst_n,
  input  logic [PWM_W:0]            amp_step,
  input  logic                      amp_sat,
  input  logic [2*N_CH-1:0]         ch_mode,
  input  logic [N_CH-1:0]           ch_en,
  input  logic [PHASE_W*N_CH-1:0]   ch_phase_ofs,
  output logic [N_CH-1:0]           pulse,
  output logic                      period_start,
  output logic                      amp_wrap
);

  localparam int AW = PWM_W + 1;
  localparam logic [PWM_W:0]   AMP_MAX = {1'b1, {PWM_W{1'b0}}};
  localparam logic [PHASE_W-1:0] WIN_LO = PHASE_W'(2 ** (PHASE_W - 2));
  localparam logic [PHASE_W-1:0] WIN_HI = PHASE_W'(3 * (2 ** (PHASE_W - 2)));

  logic [PWM_W-1:0]   pwm_cnt;
  logic [PHASE_W-1:0] phase;
  logic [PWM_W:0]     amp;
  logic               tick;
  logic               env_end;
  logic [PWM_W+1:0]   amp_sum;

  assign tick    = &pwm_cnt;
  assign env_end = tick & (&phase);
  // One extra bit so overflow past AMP_MAX is visible before clamping/wrapping
  assign amp_sum = {1'b0, amp} + {1'b0, amp_step};

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      phase        <= '0;
      amp          <= '0;
      period_start <= 1'b0;
      amp_wrap     <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + 1'b1;
      period_start <= tick;
      amp_wrap     <= 1'b0;
      if (tick) phase <= phase + 1'b1;
      if (env_end) begin
        if (amp_sum <= {1'b0, AMP_MAX}) begin
          amp <= amp_sum[PWM_W:0];
        end else if (amp_sat) begin
          amp      <= AMP_MAX;
          amp_wrap <= (amp != AMP_MAX);
        end else begin
          amp      <= '0;
          amp_wrap <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0]         mode;
    logic [PHASE_W-1:0] ph;
    logic [PHASE_W-2:0] tri_t;
    logic [PWM_W:0]     target;
    logic [PWM_W:0]     duty_q;
    logic               pulse_r;

    assign mode  = ch_mode[2*g +: 2];
    // Uses the pre-increment phase: this selects the duty for the period about to start
    assign ph    = phase + ch_phase_ofs[g*PHASE_W +: PHASE_W];
    assign tri_t = ph[PHASE_W-1] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0];

    always_comb begin
      target = '0;
      case (mode)
        2'b01:   if (ph >= WIN_LO && ph < WIN_HI) target = amp;
        2'b10:   target = amp;
        2'b11:   target = AW'(({{AW{1'b0}}, tri_t} * {{(PHASE_W-1){1'b0}}, amp}) >> (PHASE_W - 1));
        default: target = '0;
      endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        duty_q  <= '0;
        pulse_r <= 1'b0;
      end else begin
        if (tick) duty_q <= target;
        pulse_r <= ({1'b0, pwm_cnt} < duty_q) & ch_en[g];
      end
    end

    assign pulse[g] = pulse_r;
  end

endmodule

// File: tb/tb_pwm_envelope_gen.sv
// Self-checking bench for pwm_envelope_gen (PWM_W=4, PHASE_W=4, N_CH=2).
// Expected outputs come from a closed-form model indexed by clock edges since reset release.
module tb_pwm_envelope_gen;

  localparam int PER     = 16;
  localparam int NPH     = 16;
  localparam int ENV     = PER * NPH;
  localparam int AMP_MAX = 16;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic [4:0] amp_step = '0;
  logic       amp_sat = 1'b0;
  logic [3:0] ch_mode = '0;
  logic [1:0] ch_en = '0;
  logic [7:0] ch_phase_ofs = '0;
  logic [1:0] pulse;
  logic       period_start;
  logic       amp_wrap;

  pwm_envelope_gen #(.PWM_W(4), .PHASE_W(4), .N_CH(2)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .amp_step(amp_step), .amp_sat(amp_sat),
    .ch_mode(ch_mode), .ch_en(ch_en), .ch_phase_ofs(ch_phase_ofs),
    .pulse(pulse), .period_start(period_start), .amp_wrap(amp_wrap)
  );

  always #5 sysclk = ~sysclk;

  // Rising edges seen since reset release
  int e_cnt = 0;
  always @(posedge sysclk or negedge rst_n)
    if (!rst_n) e_cnt <= 0;
    else        e_cnt <= e_cnt + 1;

  int n_chk = 0;
  int n_fail = 0;

  int cfg_step;
  bit cfg_sat;
  int cfg_mode[2];
  int cfg_ofs[2];
  bit cfg_en[2];

  // Amplitude after j envelope boundaries
  function automatic int amp_at(int j);
    int a = 0;
    for (int k = 0; k < j; k++) begin
      if (a + cfg_step <= AMP_MAX) a = a + cfg_step;
      else if (cfg_sat)            a = AMP_MAX;
      else                         a = 0;
    end
    return a;
  endfunction

  // Duty in force during PWM period p (period 0 is the one right after reset)
  function automatic int duty_of(int ch, int p);
    int ph, a, t;
    if (p < 1) return 0;
    ph = (p - 1 + cfg_ofs[ch]) % NPH;
    a  = amp_at((p - 1) / NPH);
    case (cfg_mode[ch])
      1:       return (ph >= 4 && ph < 12) ? a : 0;
      2:       return a;
      3: begin
        t = (ph < 8) ? ph : 15 - ph;
        return (t * a) / 8;
      end
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_pulse(int ch, int e);
    if (e < 1) return 1'b0;
    return cfg_en[ch] && (((e - 1) % PER) < duty_of(ch, (e - 1) / PER));
  endfunction

  function automatic bit exp_pstart(int e);
    return (e >= 1) && (e % PER == 0);
  endfunction

  function automatic bit exp_wrap(int e);
    int a;
    if (e < ENV || (e % ENV) != 0) return 1'b0;
    a = amp_at(e / ENV - 1);
    return (a + cfg_step > AMP_MAX) && (!cfg_sat || a != AMP_MAX);
  endfunction

  task automatic drive_cfg();
    amp_step     = 5'(cfg_step);
    amp_sat      = cfg_sat;
    ch_mode      = {2'(cfg_mode[1]), 2'(cfg_mode[0])};
    ch_phase_ofs = {4'(cfg_ofs[1]), 4'(cfg_ofs[0])};
    ch_en        = {cfg_en[1], cfg_en[0]};
  endtask

  task automatic set_cfg(int step, bit sat, int m0, int m1, int o0, int o1, bit en0, bit en1);
    cfg_step = step; cfg_sat = sat;
    cfg_mode[0] = m0; cfg_mode[1] = m1;
    cfg_ofs[0] = o0;  cfg_ofs[1] = o1;
    cfg_en[0] = en0;  cfg_en[1] = en1;
    drive_cfg();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_cfg(5, 1'b1, 2, 2, 0, 0, 1'b1, 1'b1);
    rst_n = 1'b0;
    @(negedge sysclk);
    n_chk++; if (pulse !== 2'b00) begin n_fail++; $display("FAIL reset_pulse got %b exp 00", pulse); end
    n_chk++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_pstart got %b exp 0", period_start); end
    n_chk++; if (amp_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b exp 0", amp_wrap); end
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge sysclk);
      for (int c = 0; c < 2; c++) begin
        n_chk++;
        if (pulse[c] !== exp_pulse(c, e_cnt)) begin n_fail++; $display("FAIL reset_run pulse[%0d] e=%0d got %b exp %b", c, e_cnt, pulse[c], exp_pulse(c, e_cnt)); end
      end
      n_chk++; if (period_start !== exp_pstart(e_cnt)) begin n_fail++; $display("FAIL reset_run period_start e=%0d got %b exp %b", e_cnt, period_start, exp_pstart(e_cnt)); end
    end
  endtask

  task automatic test_constant();
    int hi = 0;
    set_cfg(5, 1'b1, 2, 0, 0, 0, 1'b1, 1'b1);
    apply_reset();
    for (int k = 0; k < 2 * ENV + 40; k++) begin
      @(negedge sysclk);
      for (int c = 0; c < 2; c++) begin
        n_chk++;
        if (pulse[c] !== exp_pulse(c, e_cnt)) begin n_fail++; $display("FAIL const pulse[%0d] e=%0d got %b exp %b", c, e_cnt, pulse[c], exp_pulse(c, e_cnt)); end
      end
      n_chk++; if (period_start !== exp_pstart(e_cnt)) begin n_fail++; $display("FAIL const period_start e=%0d got %b exp %b", e_cnt, period_start, exp_pstart(e_cnt)); end
      n_chk++; if (amp_wrap !== exp_wrap(e_cnt)) begin n_fail++; $display("FAIL const amp_wrap e=%0d got %b exp %b", e_cnt, amp_wrap, exp_wrap(e_cnt)); end
      if ((e_cnt - 1) / PER == 20) hi += int'(pulse[0]);
    end
    n_chk++; if (hi != 5) begin n_fail++; $display("FAIL const hi_count got %0d exp 5", hi); end
  endtask

  task automatic test_gated_sat();
    int wraps = 0;
    set_cfg(12, 1'b1, 1, 1, 0, 5, 1'b1, 1'b1);
    apply_reset();
    for (int k = 0; k < 4 * ENV + 20; k++) begin
      @(negedge sysclk);
      for (int c = 0; c < 2; c++) begin
        n_chk++;
        if (pulse[c] !== exp_pulse(c, e_cnt)) begin n_fail++; $display("FAIL gated pulse[%0d] e=%0d got %b exp %b", c, e_cnt, pulse[c], exp_pulse(c, e_cnt)); end
      end
      n_chk++; if (amp_wrap !== exp_wrap(e_cnt)) begin n_fail++; $display("FAIL gated amp_wrap e=%0d got %b exp %b", e_cnt, amp_wrap, exp_wrap(e_cnt)); end
      wraps += int'(amp_wrap);
    end
    n_chk++; if (wraps != 1) begin n_fail++; $display("FAIL gated wrap_count got %0d exp 1", wraps); end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    set_cfg(7, 1'b0, 2, 3, 0, 3, 1'b1, 1'b1);
    apply_reset();
    for (int k = 0; k < 4 * ENV + 40; k++) begin
      @(negedge sysclk);
      for (int c = 0; c < 2; c++) begin
        n_chk++;
        if (pulse[c] !== exp_pulse(c, e_cnt)) begin n_fail++; $display("FAIL wrap pulse[%0d] e=%0d got %b exp %b", c, e_cnt, pulse[c], exp_pulse(c, e_cnt)); end
      end
      n_chk++; if (amp_wrap !== exp_wrap(e_cnt)) begin n_fail++; $display("FAIL wrap amp_wrap e=%0d got %b exp %b", e_cnt, amp_wrap, exp_wrap(e_cnt)); end
      wraps += int'(amp_wrap);
    end
    n_chk++; if (wraps != 1) begin n_fail++; $display("FAIL wrap wrap_count got %0d exp 1", wraps); end
  endtask

  task automatic test_triangle();
    set_cfg(16, 1'b1, 3, 3, 0, 8, 1'b1, 1'b1);
    apply_reset();
    for (int k = 0; k < 2 * ENV + 20; k++) begin
      @(negedge sysclk);
      for (int c = 0; c < 2; c++) begin
        n_chk++;
        if (pulse[c] !== exp_pulse(c, e_cnt)) begin n_fail++; $display("FAIL tri pulse[%0d] e=%0d got %b exp %b", c, e_cnt, pulse[c], exp_pulse(c, e_cnt)); end
      end
      n_chk++; if (period_start !== exp_pstart(e_cnt)) begin n_fail++; $display("FAIL tri period_start e=%0d got %b exp %b", e_cnt, period_start, exp_pstart(e_cnt)); end
    end
  endtask

  // Mode change at pwm_cnt=7 and enable toggling at pwm_cnt=2/5 in later periods
  task automatic test_mid_period();
    set_cfg(12, 1'b1, 2, 2, 0, 0, 1'b1, 1'b1);
    apply_reset();
    for (int k = 0; k < 380; k++) begin
      @(negedge sysclk);
      for (int c = 0; c < 2; c++) begin
        n_chk++;
        if (pulse[c] !== exp_pulse(c, e_cnt)) begin n_fail++; $display("FAIL mid pulse[%0d] e=%0d got %b exp %b", c, e_cnt, pulse[c], exp_pulse(c, e_cnt)); end
      end
      n_chk++; if (period_start !== exp_pstart(e_cnt)) begin n_fail++; $display("FAIL mid period_start e=%0d got %b exp %b", e_cnt, period_start, exp_pstart(e_cnt)); end
      if (e_cnt == 20 * PER + 7) ch_mode[1:0] = 2'b00;
      if (e_cnt == 21 * PER)     cfg_mode[0] = 0;
      if (e_cnt == 21 * PER + 2) begin ch_en[1] = 1'b0; cfg_en[1] = 1'b0; end
      if (e_cnt == 21 * PER + 5) begin ch_en[1] = 1'b1; cfg_en[1] = 1'b1; end
    end
  endtask

  task automatic test_async_reset();
    set_cfg(12, 1'b1, 2, 0, 0, 0, 1'b1, 1'b1);
    apply_reset();
    while (e_cnt < 18 * PER + 3) @(negedge sysclk);
    n_chk++; if (pulse[0] !== exp_pulse(0, e_cnt)) begin n_fail++; $display("FAIL async pre pulse got %b exp %b", pulse[0], exp_pulse(0, e_cnt)); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (pulse !== 2'b00) begin n_fail++; $display("FAIL async_rst pulse got %b exp 00", pulse); end
    n_chk++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL async_rst period_start got %b exp 0", period_start); end
    n_chk++; if (amp_wrap !== 1'b0) begin n_fail++; $display("FAIL async_rst amp_wrap got %b exp 0", amp_wrap); end
    @(negedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge sysclk);
      n_chk++;
      if (pulse[0] !== exp_pulse(0, e_cnt)) begin n_fail++; $display("FAIL async_run pulse e=%0d got %b exp %b", e_cnt, pulse[0], exp_pulse(0, e_cnt)); end
      n_chk++; if (period_start !== exp_pstart(e_cnt)) begin n_fail++; $display("FAIL async_run period_start e=%0d got %b exp %b", e_cnt, period_start, exp_pstart(e_cnt)); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      set_cfg(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      apply_reset();
      for (int k = 0; k < 3 * ENV + 20; k++) begin
        @(negedge sysclk);
        for (int c = 0; c < 2; c++) begin
          n_chk++;
          if (pulse[c] !== exp_pulse(c, e_cnt)) begin n_fail++; $display("FAIL rand%0d pulse[%0d] e=%0d got %b exp %b", it, c, e_cnt, pulse[c], exp_pulse(c, e_cnt)); end
        end
        n_chk++; if (period_start !== exp_pstart(e_cnt)) begin n_fail++; $display("FAIL rand%0d period_start e=%0d got %b exp %b", it, e_cnt, period_start, exp_pstart(e_cnt)); end
        n_chk++; if (amp_wrap !== exp_wrap(e_cnt)) begin n_fail++; $display("FAIL rand%0d amp_wrap e=%0d got %b exp %b", it, e_cnt, amp_wrap, exp_wrap(e_cnt)); end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_constant();
    test_gated_sat();
    test_wrap();
    test_triangle();
    test_mid_period();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
